// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: display word geometry and the lap-buffer state enum.
package stopwatch_pkg;

   localparam int DIGIT_W = 4;
   localparam int WORD_W  = 4 * DIGIT_W;

   typedef enum logic {
      LIVE   = 1'b0,
      RECALL = 1'b1
   } sw_state_t;

endpackage

// File: rtl/lap_store.sv
// DEPTH x WIDTH lap register array: one synchronous write port, combinational read.
module lap_store #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are deliberately left unreset; lap_count hides stale slots.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/lap_split_buffer.sv
// Stopwatch lap buffer: captures split times and lets the user step through them on the display.
//
//   state  | meaning
//   LIVE   | display follows the running stopwatch digits
//   RECALL | display shows stored lap rd_idx; idle timer returns to LIVE
module lap_split_buffer
   import stopwatch_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 200_000_000
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WORD_W-1:0]        live_digits,
   input  logic                     lap,
   input  logic                     recall,
   input  logic                     clear,
   output logic [WORD_W-1:0]        dataOut,
   output logic                     showing_lap,
   output logic [$clog2(DEPTH):0]   lap_count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT);

   sw_state_t         state, state_nx;
   logic [AW-1:0]     rd_idx, rd_idx_nx;
   logic [TW-1:0]     tmr, tmr_nx;
   logic              full, last, we;
   logic [WORD_W-1:0] rdata;

   assign full = (lap_count == CW'(DEPTH));
   assign last = (CW'(rd_idx) == lap_count - CW'(1));

   lap_store #(
      .DEPTH (DEPTH),
      .WIDTH (WORD_W)
   ) u_store (
      .clk   (clk),
      .we    (we),
      .waddr (lap_count[AW-1:0]),
      .wdata (live_digits),
      .raddr (rd_idx),
      .rdata (rdata)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= LIVE;
         rd_idx <= '0;
         tmr    <= '0;
      end else begin
         state  <= state_nx;
         rd_idx <= rd_idx_nx;
         tmr    <= tmr_nx;
      end
   end

   always_comb begin
      state_nx  = state;
      rd_idx_nx = rd_idx;
      tmr_nx    = tmr;
      we        = 1'b0;
      if (clear) begin
         state_nx  = LIVE;
         rd_idx_nx = '0;
         tmr_nx    = '0;
      end else begin
         unique case (state)
            LIVE: begin
               if (recall && lap_count != '0) begin
                  state_nx  = RECALL;
                  rd_idx_nx = '0;
                  tmr_nx    = '0;
               end
            end
            RECALL: begin
               if (recall) begin
                  tmr_nx = '0;
                  if (last) begin
                     state_nx  = LIVE;
                     rd_idx_nx = '0;
                  end else begin
                     rd_idx_nx = rd_idx + AW'(1);
                  end
               end else if (tmr == TW'(TIMEOUT - 1)) begin
                  state_nx  = LIVE;
                  rd_idx_nx = '0;
                  tmr_nx    = '0;
               end else begin
                  tmr_nx = tmr + TW'(1);
               end
            end
            default: state_nx = LIVE;
         endcase
         // Recall above decides on the pre-edge count, so a same-cycle lap never races it.
         we = lap && !full;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lap_count <= '0;
         overflow  <= 1'b0;
      end else if (clear) begin
         lap_count <= '0;
         overflow  <= 1'b0;
      end else if (lap) begin
         if (full) overflow  <= 1'b1;
         else      lap_count <= lap_count + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         dataOut     <= '0;
         showing_lap <= 1'b0;
      end else begin
         dataOut     <= (state == RECALL) ? rdata : live_digits;
         showing_lap <= (state == RECALL);
      end
   end

endmodule

// File: tb/tb_lap_split_buffer.sv
// Scoreboard bench for lap_split_buffer: directed scenarios then random pulses against a queue-based model.
module tb_lap_split_buffer;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 10;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] live_digits = '0;
   logic        lap = 1'b0, recall = 1'b0, clear = 1'b0;
   logic [15:0] dataOut;
   logic        showing_lap;
   logic [2:0]  lap_count;
   logic        overflow;

   lap_split_buffer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .reset       (reset),
      .live_digits (live_digits),
      .lap         (lap),
      .recall      (recall),
      .clear       (clear),
      .dataOut     (dataOut),
      .showing_lap (showing_lap),
      .lap_count   (lap_count),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] data;
      logic        show;
      int          cnt;
      logic        ovf;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] laps[$];
   bit          m_rec;
   int          m_idx, m_idle;
   bit          m_ovf;
   int          n_checks = 0;
   int          n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      laps.delete();
      m_rec = 0; m_idx = 0; m_idle = 0; m_ovf = 0;
   endtask

   // One clock of stimulus; the model predicts what the outputs show after this edge.
   task automatic cycle(input bit l, input bit r, input bit c, input logic [15:0] d);
      exp_t e;
      int   n;
      @(negedge clk);
      #1;
      lap = l; recall = r; clear = c; live_digits = d;
      e.data = m_rec ? laps[m_idx] : d;
      e.show = m_rec;
      n = laps.size();
      if (c) begin
         model_reset();
      end else begin
         if (m_rec) begin
            if (r) begin
               m_idle = 0;
               if (m_idx < n - 1) m_idx++;
               else m_rec = 0;
            end else if (m_idle == TIMEOUT - 1) begin
               m_rec = 0;
            end else begin
               m_idle++;
            end
         end else if (r && n > 0) begin
            m_rec = 1; m_idx = 0; m_idle = 0;
         end
         if (l) begin
            if (n < DEPTH) laps.push_back(d);
            else m_ovf = 1;
         end
      end
      e.cnt = laps.size();
      e.ovf = m_ovf;
      sb.push_back(e);
      @(posedge clk);
      #1;
      lap = 0; recall = 0; clear = 0;
   endtask

   task automatic idle(input int k, input logic [15:0] d);
      for (int i = 0; i < k; i++) cycle(0, 0, 0, d);
   endtask

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         check("dataOut", 32'(dataOut), 32'(e.data));
         check("showing_lap", 32'(showing_lap), 32'(e.show));
         check("lap_count", 32'(lap_count), 32'(e.cnt));
         check("overflow", 32'(overflow), 32'(e.ovf));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_dataOut", 32'(dataOut), 32'h0);
      check("rst_showing_lap", 32'(showing_lap), 32'h0);
      check("rst_lap_count", 32'(lap_count), 32'h0);
      check("rst_overflow", 32'(overflow), 32'h0);
      @(negedge clk);
      #1 reset = 1'b1;

      // Live passthrough
      idle(2, 16'h1234);

      // Three laps, step through them, fourth recall returns to live
      cycle(1, 0, 0, 16'h0105);
      cycle(1, 0, 0, 16'h0210);
      cycle(1, 0, 0, 16'h0333);
      for (int i = 0; i < 4; i++) begin
         cycle(0, 1, 0, 16'h7777);
         idle(2, 16'h7777);
      end

      // Fill, overflow, recall everything, clear
      cycle(1, 0, 0, 16'h0444);
      cycle(1, 0, 0, 16'h0555);
      for (int i = 0; i < 5; i++) cycle(0, 1, 0, 16'h0606);
      idle(1, 16'h0606);
      cycle(0, 0, 1, 16'h0707);
      idle(1, 16'h0707);

      // Idle timeout, then timeout restart by an intermediate recall
      cycle(1, 0, 0, 16'h1111);
      cycle(1, 0, 0, 16'h2222);
      cycle(0, 1, 0, 16'h3333);
      idle(12, 16'h3333);
      cycle(0, 1, 0, 16'h4444);
      idle(4, 16'h4444);
      cycle(0, 1, 0, 16'h4444);
      idle(12, 16'h4545);

      // Same-cycle lap+recall on empty buffer, lap+clear
      cycle(0, 0, 1, 16'h0000);
      cycle(1, 1, 0, 16'h5959);
      idle(2, 16'h6060);
      cycle(1, 0, 1, 16'h6161);
      idle(1, 16'h6262);

      // Asynchronous reset in the middle of recall
      cycle(1, 0, 0, 16'h0909);
      cycle(0, 1, 0, 16'h0808);
      idle(2, 16'h0808);
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("async_rst_dataOut", 32'(dataOut), 32'h0);
      check("async_rst_showing_lap", 32'(showing_lap), 32'h0);
      check("async_rst_lap_count", 32'(lap_count), 32'h0);
      check("async_rst_overflow", 32'(overflow), 32'h0);
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 reset = 1'b1;
      cycle(0, 1, 0, 16'h0101);
      idle(2, 16'h0202);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         cycle($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 59) == 0, 16'($urandom));
      end

      repeat (3) @(negedge clk);
      if (sb.size() != 0) check("scoreboard_drained", 32'(sb.size()), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
